pc_gen: RTL and testbench

//  Parametrised program-counter generator for the IF stage. Successor to the fixed
//  32-bit PC: configurable width, reset vector and instruction-memory window.

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_ras.sv | 54 +++++
 rtl/pc_gen.sv | 107 ++++++++++
 tb/tb_pc_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared enums for the program-counter generator
package pc_pkg;

  typedef enum logic [1:0] {
    HC_NONE     = 2'd0,
    HC_OOB      = 2'd1,
    HC_MISALIGN = 2'd2,
    HC_RAS_UFL  = 2'd3
  } halt_cause_e;

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'd0,
    SEL_IMM  = 2'd1,
    SEL_RET  = 2'd2,
    SEL_TRAP = 2'd3
  } sel_e;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; a push when full overwrites the oldest entry
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(RAS_DEPTH);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  // sp is the next free slot; once full it also points at the oldest entry
  logic [PW-1:0]   sp;
  logic [PW:0]     count;
  logic [PW-1:0]   top_idx;
  logic            do_pop;

  assign top_idx = sp - PW'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(RAS_DEPTH));
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sp    <= '0;
      count <= '0;
    end else if (push && do_pop) begin
      sp    <= sp;
      count <= count;
    end else if (push) begin
      sp <= sp + PW'(1);
      if (!full) count <= count + (PW+1)'(1);
    end else if (do_pop) begin
      sp    <= sp - PW'(1);
      count <= count - (PW+1)'(1);
    end
  end

  // Simultaneous push and pop replaces the top entry in place
  always_ff @(posedge clk) begin
    if (push) mem[do_pop ? top_idx : sp] <= push_data;
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - IF-stage program counter with trap/branch/return redirect and sticky fault halt
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(32'h0100_0000),
  parameter logic [XLEN-1:0] IMEM_BASE  = XLEN'(32'h0100_0000),
  parameter int              IMEM_BYTES = 2048,
  parameter int              RAS_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            we,
  input  logic            imm,
  input  logic [XLEN-1:0] imm_addr,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            call,
  input  logic            ret,
  output logic [XLEN-1:0] instr_addr,
  output logic            halt,
  output logic [1:0]      halt_cause,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam logic [XLEN-1:0] IMEM_LAST = IMEM_BASE + XLEN'(IMEM_BYTES - 4);

  logic [XLEN-1:2] pc;
  logic [XLEN-1:0] seq_addr;
  logic [XLEN-1:0] next_addr;
  logic [XLEN-1:0] ras_top;
  sel_e            sel;
  halt_cause_e     fault_cause;
  halt_cause_e     cause_q;
  logic            adv;
  logic            commit;
  logic            ras_push;
  logic            ras_pop;

  assign instr_addr = {pc, 2'b00};
  assign seq_addr   = instr_addr + XLEN'(4);
  assign halt_cause = cause_q;

  always_comb begin
    sel = SEL_SEQ;
    if (trap)     sel = SEL_TRAP;
    else if (ret) sel = SEL_RET;
    else if (imm) sel = SEL_IMM;
  end

  always_comb begin
    next_addr = seq_addr;
    case (sel)
      SEL_TRAP: next_addr = trap_vec;
      SEL_RET:  next_addr = ras_top;
      SEL_IMM:  next_addr = imm_addr;
      default:  next_addr = seq_addr;
    endcase
  end

  // Fault checks in descending cause priority
  always_comb begin
    fault_cause = HC_NONE;
    if (sel == SEL_RET && ras_empty)
      fault_cause = HC_RAS_UFL;
    else if (next_addr[1:0] != 2'b00)
      fault_cause = HC_MISALIGN;
    else if (next_addr < IMEM_BASE || next_addr > IMEM_LAST)
      fault_cause = HC_OOB;
  end

  assign adv      = we && !halt;
  assign commit   = adv && (fault_cause == HC_NONE);
  assign ras_push = commit && call;
  assign ras_pop  = commit && (sel == SEL_RET);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc      <= RESET_VEC[XLEN-1:2];
      halt    <= 1'b0;
      cause_q <= HC_NONE;
    end else if (adv) begin
      if (fault_cause != HC_NONE) begin
        halt    <= 1'b1;
        cause_q <= fault_cause;
      end else begin
        pc <= next_addr[XLEN-1:2];
      end
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rstn      (rstn),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq_addr),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - table-driven directed bench for pc_gen
module tb_pc_gen;

  localparam logic [31:0] B = 32'h0100_0000;

  logic        clk;
  logic        rstn;
  logic        we;
  logic        imm;
  logic [31:0] imm_addr;
  logic        trap;
  logic [31:0] trap_vec;
  logic        call;
  logic        ret;
  logic [31:0] instr_addr;
  logic        halt;
  logic [1:0]  halt_cause;
  logic        ras_empty;
  logic        ras_full;

  int checks   = 0;
  int failures = 0;

  pc_gen dut (
    .clk        (clk),
    .rstn       (rstn),
    .we         (we),
    .imm        (imm),
    .imm_addr   (imm_addr),
    .trap       (trap),
    .trap_vec   (trap_vec),
    .call       (call),
    .ret        (ret),
    .instr_addr (instr_addr),
    .halt       (halt),
    .halt_cause (halt_cause),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          we;
    bit          trap;
    bit          ret;
    bit          call;
    bit          imm;
    logic [31:0] imm_addr;
    logic [31:0] trap_vec;
    logic [31:0] e_addr;
    bit          e_halt;
    logic [1:0]  e_cause;
    bit          e_empty;
    bit          e_full;
  } vec_t;

  vec_t vq[$];

  function automatic void add(bit r, bit w, bit tr, bit rt, bit cl, bit im,
                              logic [31:0] ia, logic [31:0] tv, logic [31:0] ea,
                              bit eh, logic [1:0] ec, bit ee, bit ef);
    vec_t v;
    v.rst = r; v.we = w; v.trap = tr; v.ret = rt; v.call = cl; v.imm = im;
    v.imm_addr = ia; v.trap_vec = tv; v.e_addr = ea;
    v.e_halt = eh; v.e_cause = ec; v.e_empty = ee; v.e_full = ef;
    vq.push_back(v);
  endfunction

  function automatic void add_rst();
    add(1, 0, 0, 0, 0, 0, 0, 0, B, 0, 0, 1, 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ea, input bit eh,
                         input logic [1:0] ec, input bit ee, input bit ef);
    chk({tag, " instr_addr"}, instr_addr, ea);
    chk({tag, " halt"}, {31'd0, halt}, {31'd0, eh});
    chk({tag, " halt_cause"}, {30'd0, halt_cause}, {30'd0, ec});
    chk({tag, " ras_empty"}, {31'd0, ras_empty}, {31'd0, ee});
    chk({tag, " ras_full"}, {31'd0, ras_full}, {31'd0, ef});
  endtask

  task automatic drive(input bit w, input bit tr, input bit rt, input bit cl, input bit im,
                       input logic [31:0] ia, input logic [31:0] tv);
    @(negedge clk);
    we = w; trap = tr; ret = rt; call = cl; imm = im; imm_addr = ia; trap_vec = tv;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    we = 0; trap = 0; ret = 0; call = 0; imm = 0;
    rstn = 1'b0;
    #1;
  endtask

  logic [31:0] pushed[$];
  logic [31:0] cur;
  logic [31:0] tgt;

  initial begin
    rstn = 1'b0; we = 0; imm = 0; imm_addr = 0; trap = 0; trap_vec = 0; call = 0; ret = 0;

    add_rst();
    add(0, 1, 0, 0, 0, 0, 0, 0, B + 32'h04, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, B + 32'h08, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, B + 32'h0C, 0, 0, 1, 0);
    add(0, 0, 1, 1, 1, 1, B + 32'h100, B + 32'h200, B + 32'h0C, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, B + 32'h0C, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, B + 32'h10, 0, 0, 1, 0);
    add(0, 1, 0, 0, 1, 1, B + 32'h100, 0, B + 32'h100, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, B + 32'h14, 0, 0, 1, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, B + 32'h18, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, B + 32'h1C, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, B + 32'h20, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, B + 32'h24, 0, 0, 0, 1);
    add(0, 1, 0, 0, 1, 0, 0, 0, B + 32'h28, 0, 0, 0, 1);
    add(0, 1, 0, 1, 0, 0, 0, 0, B + 32'h28, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, B + 32'h24, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, B + 32'h20, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, B + 32'h1C, 0, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, B + 32'h1C, 1, 3, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, B + 32'h1C, 1, 3, 1, 0);
    add_rst();
    add(0, 1, 0, 0, 0, 1, B + 32'h102, 0, B, 1, 2, 1, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, B, 1, 2, 1, 0);
    add_rst();
    add(0, 1, 1, 0, 0, 1, B + 32'h300, B + 32'h200, B + 32'h200, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, B + 32'h7F8, 0, B + 32'h7F8, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, B + 32'h7FC, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, B + 32'h7FC, 1, 1, 1, 0);
    add_rst();
    add(0, 1, 1, 0, 0, 0, 0, 32'h0000_0002, B, 1, 2, 1, 0);
    add_rst();
    add(0, 1, 0, 0, 0, 1, 32'h00FF_FFFC, 0, B, 1, 1, 1, 0);
    add_rst();
    add(0, 1, 0, 0, 0, 1, B + 32'h800, 0, B, 1, 1, 1, 0);
    add_rst();
    add(0, 1, 0, 1, 0, 1, B + 32'h101, 0, B, 1, 3, 1, 0);
    add_rst();
    add(0, 1, 1, 0, 1, 0, 0, B + 32'h400, B + 32'h400, 0, 0, 0, 0);
    add(0, 1, 0, 1, 1, 0, 0, 0, B + 32'h04, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 1, B + 32'h500, 0, B + 32'h404, 0, 0, 1, 0);

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].rst) pulse_reset();
      else drive(vq[i].we, vq[i].trap, vq[i].ret, vq[i].call, vq[i].imm,
                 vq[i].imm_addr, vq[i].trap_vec);
      chk_all($sformatf("row%0d", i), vq[i].e_addr, vq[i].e_halt, vq[i].e_cause,
              vq[i].e_empty, vq[i].e_full);
      if (vq[i].rst) rstn = 1'b1;
    end

    // Six jal-style calls to distinct targets, then unwind past the oldest surviving entry
    pulse_reset();
    rstn = 1'b1;
    cur = B;
    for (int i = 0; i < 6; i++) begin
      tgt = B + 32'h100 + 32'(i) * 32'h20;
      drive(1, 0, 0, 1, 1, tgt, 0);
      pushed.push_back(cur + 32'h4);
      cur = tgt;
      chk_all($sformatf("jal%0d", i), cur, 0, 0, 0, i >= 3);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 1, 0, 0, 0, 0);
      cur = pushed[5 - k];
      chk_all($sformatf("unwind%0d", k), cur, 0, 0, k == 3, 0);
    end
    drive(1, 0, 1, 0, 0, 0, 0);
    chk_all("unwind_ufl", cur, 1, 3, 1, 0);
    drive(1, 1, 0, 0, 0, 0, B + 32'h200);
    chk_all("halt_frozen", cur, 1, 3, 1, 0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk_all("midrun_reset", B, 0, 0, 1, 0);
    rstn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
